vec_wb_collector: RTL

- Receiving end of the vec_alu lane result interface.
- Accepts per-lane element results (data + bit index + done) from up to 4 lanes and assembles them into one VLEN-bit destination buffer.
- When the full vector is complete, issues a valid/ready writeback to the vector register file.
- Sits between the vec_alu lane array and the vector register file write port.

---
 rtl/vec_wb_collector.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vec_wb_collector.sv
// rtl/vec_wb_collector.sv - assembles per-lane element results into one VLEN-bit vector writeback
// Optional macro VEC_WB_BYTEMASK_EN adds the wb_bytemask output (bytes written this collection).
module vec_wb_collector #(
   parameter int VLEN   = 128,
   parameter int LANE_W = 64,
   parameter int IDX_W  = 10
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic [2:0]          vsew,
   input  logic [1:0]          nb_lanes,
   input  logic [4:0]          vd_addr,
   output logic                busy,
   input  logic [3:0]          lane_valid,
   input  logic [4*LANE_W-1:0] lane_data,
   input  logic [4*IDX_W-1:0]  lane_index,
   input  logic [3:0]          lane_done,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [4:0]          wb_addr,
   output logic [VLEN-1:0]     wb_data,
`ifdef VEC_WB_BYTEMASK_EN
   output logic [VLEN/8-1:0]   wb_bytemask,
`endif
   output logic                err
);

   localparam int NB    = VLEN / 8;
   localparam int BA_W  = $clog2(NB);
   localparam int CNT_W = BA_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WB} state_t;

   state_t            r_state, w_state_next;
   logic [1:0]        r_vsew;
   logic [1:0]        r_nb_lanes;
   logic [4:0]        r_vd_addr;
   logic [VLEN-1:0]   r_buf, w_buf_next, w_buf_upd;
   logic [NB-1:0]     r_written, w_written_next, w_wr_upd;
   logic [CNT_W-1:0]  r_count, w_count_next, w_cnt_upd;
   logic [3:0]        r_done_seen, w_done_next, w_done_upd;
   logic              r_err, w_err_next;
   logic              w_clear;

   logic [31:0]       w_ew;
   logic [31:0]       w_need;
   logic [7:0]        w_emask;
   logic [3:0]        w_act, w_align, w_fit, w_ok, w_bad, w_win, w_new;
   logic              w_dup;
   logic [2:0]        w_inc;
   logic [IDX_W-1:0]  w_idx [4];
   logic [BA_W-1:0]   w_ba  [4];

   // Per-lane classification: legal write, rejected write, collision loser, first write of element
   always_comb begin
      w_ew = 32'd8 << r_vsew;
      case (r_nb_lanes)
         2'd0:    w_act = 4'b0001;
         2'd1:    w_act = 4'b0011;
         default: w_act = 4'b1111;
      endcase
      w_align = '0;
      w_fit   = '0;
      w_ok    = '0;
      w_bad   = '0;
      w_win   = '0;
      w_new   = '0;
      w_inc   = '0;
      for (int i = 0; i < 4; i++) begin
         w_idx[i]   = lane_index[i*IDX_W +: IDX_W];
         w_ba[i]    = BA_W'(w_idx[i] >> 3);
         w_align[i] = ((32'(w_idx[i]) & (w_ew - 32'd1)) == 32'd0);
         w_fit[i]   = ((32'(w_idx[i]) + w_ew) <= 32'(VLEN));
         w_ok[i]    = (r_state == S_COLLECT) && w_act[i] && lane_valid[i] && w_align[i] && w_fit[i];
         w_bad[i]   = (r_state == S_COLLECT) && w_act[i] && lane_valid[i] && !(w_align[i] && w_fit[i]);
      end
      for (int i = 0; i < 4; i++) begin
         w_win[i] = w_ok[i];
         for (int j = i + 1; j < 4; j++) begin
            if (w_ok[j] && (w_idx[j] == w_idx[i])) begin
               w_win[i] = 1'b0;
            end
         end
         w_new[i] = w_win[i] && !r_written[w_ba[i]];
         w_inc    = w_inc + {2'b00, w_new[i]};
      end
      w_dup = |(w_ok & ~w_win);
   end

   always_comb begin
      case (r_vsew)
         2'd0:    w_emask = 8'h01;
         2'd1:    w_emask = 8'h03;
         2'd2:    w_emask = 8'h0f;
         default: w_emask = 8'hff;
      endcase
      w_buf_upd = r_buf;
      w_wr_upd  = r_written;
      // Ascending lane order lets the higher lane overwrite on an index collision
      for (int i = 0; i < 4; i++) begin
         if (w_ok[i]) begin
            for (int j = 0; j < 8; j++) begin
               if (w_emask[j]) begin
                  w_buf_upd[{w_ba[i] + BA_W'(j), 3'b000} +: 8] = lane_data[i*LANE_W + j*8 +: 8];
                  w_wr_upd[w_ba[i] + BA_W'(j)] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_buf_next     = r_buf;
      w_written_next = r_written;
      w_count_next   = r_count;
      w_done_next    = r_done_seen;
      w_err_next     = r_err;
      w_clear        = 1'b0;
      w_need         = 32'(VLEN) >> ({1'b0, r_vsew} + 3'd3);
      w_cnt_upd      = r_count + CNT_W'(w_inc);
      w_done_upd     = r_done_seen | (lane_done & w_act);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (vsew <= 3'd3) begin
                  w_state_next = S_COLLECT;
                  w_clear      = 1'b1;
               end else begin
                  w_err_next = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            w_buf_next     = w_buf_upd;
            w_written_next = w_wr_upd;
            w_count_next   = w_cnt_upd;
            w_done_next    = w_done_upd;
            if ((|w_bad) || w_dup) begin
               w_err_next = 1'b1;
            end
            if (32'(w_cnt_upd) == w_need) begin
               w_state_next = S_WB;
            end else if ((w_done_upd & w_act) == w_act) begin
               w_state_next = S_WB;
               w_err_next   = 1'b1;
            end
         end
         S_WB: begin
            if (wb_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_vsew      <= '0;
         r_nb_lanes  <= '0;
         r_vd_addr   <= '0;
         r_buf       <= '0;
         r_written   <= '0;
         r_count     <= '0;
         r_done_seen <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_clear) begin
            r_vsew      <= vsew[1:0];
            r_nb_lanes  <= nb_lanes;
            r_vd_addr   <= vd_addr;
            r_buf       <= '0;
            r_written   <= '0;
            r_count     <= '0;
            r_done_seen <= '0;
            r_err       <= 1'b0;
         end else begin
            r_buf       <= w_buf_next;
            r_written   <= w_written_next;
            r_count     <= w_count_next;
            r_done_seen <= w_done_next;
            r_err       <= w_err_next;
         end
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign wb_valid = (r_state == S_WB);
   assign wb_addr  = r_vd_addr;
   assign wb_data  = r_buf;
   assign err      = r_err;
`ifdef VEC_WB_BYTEMASK_EN
   assign wb_bytemask = r_written;
`endif

endmodule
